// File: rtl/serial_subtractor16_pkg.sv
// rtl/serial_subtractor16_pkg.sv - shared types and constants for the serial subtractor
//
// Purpose: state encoding and the default operand width used by the
//          bit-serial subtractor and its full-subtractor cell.
// Contents:
//   WIDTH_DEFAULT  default operand/result width in bits
//   state_t        control FSM states (IDLE, RUN, DONE)
package serial_subtractor16_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor16_full_subtractor.sv
// rtl/serial_subtractor16_full_subtractor.sv - single-bit combinational full subtractor
//
// Purpose: computes one bit of x - y - bin.
// Ports:
//   x     input   minuend bit
//   y     input   subtrahend bit
//   bin   input   borrow in
//   d     output  difference bit
//   bout  output  borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor16.sv
// rtl/serial_subtractor16.sv - bit-serial subtractor D = A - B with borrow/overflow/zero flags
//
// Purpose: subtracts two WIDTH-bit operands one bit per clock through a single
//          full-subtractor cell, LSB first, with a start/done handshake.
// Ports:
//   Clk    input          system clock, rising edge
//   Reset  input          asynchronous active-high reset
//   Start  input          request, sampled only in IDLE
//   A      input  [W-1:0] minuend, captured on the accepting edge
//   B      input  [W-1:0] subtrahend, captured on the accepting edge
//   Busy   output         high while bits are being processed
//   Done   output         one-cycle pulse when D and the flags are fresh
//   D      output [W-1:0] difference modulo 2^WIDTH, held until next result
//   Bout   output         final borrow (A < B unsigned)
//   V      output         signed overflow of A - B
//   Z      output         D == 0
import serial_subtractor16_pkg::*;

module serial_subtractor16 #(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    localparam int CW = $clog2(WIDTH + 1);
    // Count value on the final RUN edge; that edge brings count up to WIDTH.
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    count;
    logic             borrow;
    logic             sign_a;
    logic             sign_b;

    logic             cell_d;
    logic             cell_bout;
    logic             last_bit;

    full_subtractor u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Result fills from the MSB side so that after WIDTH shifts bit 0 lands in res[0].
    assign res_next = {cell_d, res[WIDTH-1:1]};
    assign last_bit = (count == LAST_COUNT);

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state)
            RUN:     Busy = 1'b1;
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, serial shift, result and flag registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            count  <= '0;
            borrow <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
            V      <= 1'b0;
            Z      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        sa     <= A;
                        sb     <= B;
                        sign_a <= A[WIDTH-1];
                        sign_b <= B[WIDTH-1];
                        borrow <= 1'b0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    res    <= res_next;
                    borrow <= cell_bout;
                    count  <= count + CW'(1);
                    if (last_bit) begin
                        D    <= res_next;
                        Bout <= cell_bout;
                        // Overflow: operand signs differ and the result sign
                        // disagrees with the minuend.
                        V    <= (sign_a != sign_b) && (res_next[WIDTH-1] != sign_a);
                        Z    <= (res_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor16.sv
// tb/tb_serial_subtractor16.sv - self-checking bench for serial_subtractor16
module tb_serial_subtractor16;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         v;
    logic         z;

    int checks;
    int failures;

    serial_subtractor16 #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .Start (start),
        .A     (a),
        .B     (b),
        .Busy  (busy),
        .Done  (done),
        .D     (d),
        .Bout  (bout),
        .V     (v),
        .Z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_d;
        logic         exp_bout;
        logic         exp_v;
        logic         exp_z;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " d"},    {16'd0, d},    32'd0);
        check({tag, " bout"}, {31'd0, bout}, 32'd0);
        check({tag, " v"},    {31'd0, v},    32'd0);
        check({tag, " z"},    {31'd0, z},    32'd0);
    endtask

    // Runs one operation from IDLE; operands are scrambled after capture.
    // Called at a negedge; returns at the negedge where Done is seen.
    task automatic do_op(input vec_t t, input string tag);
        int busy_cnt;
        int done_at;
        int both;
        busy_cnt = 0;
        done_at  = -1;
        both     = 0;
        start = 1'b1;
        a     = t.a;
        b     = t.b;
        for (int n = 1; n <= 40 && done_at < 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                a     = ~t.a;
                b     = t.a ^ t.b ^ 16'h5A5A;
            end
            if (busy) busy_cnt++;
            if (busy && done) both++;
            if (done) done_at = n;
        end
        check({tag, " done_cycle"}, done_at, 32'd17);
        check({tag, " busy_cycles"}, busy_cnt, 32'd16);
        check({tag, " busy_and_done"}, both, 32'd0);
        check({tag, " d"},    {16'd0, d},    {16'd0, t.exp_d});
        check({tag, " bout"}, {31'd0, bout}, {31'd0, t.exp_bout});
        check({tag, " v"},    {31'd0, v},    {31'd0, t.exp_v});
        check({tag, " z"},    {31'd0, z},    {31'd0, t.exp_z});
        @(negedge clk);
        check({tag, " done_pulse_width"}, {31'd0, done}, 32'd0);
        check({tag, " d_held"}, {16'd0, d}, {16'd0, t.exp_d});
    endtask

    initial begin
        vec_t t;
        int   done_cnt;
        int   busy_late;

        checks   = 0;
        failures = 0;

        vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Start during RUN is ignored and not queued.
        done_cnt  = 0;
        busy_late = 0;
        start = 1'b1;
        a     = 16'h0010;
        b     = 16'h0001;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 5) begin
                start = 1'b1;
                a     = 16'hFFFF;
                b     = 16'hFFFF;
            end
            if (done) begin
                done_cnt++;
                check("ignored_start d", {16'd0, d}, 32'h0000_000F);
                check("ignored_start z", {31'd0, z}, 32'd0);
            end
            if (n > 18 && busy) busy_late++;
        end
        check("ignored_start done_count", done_cnt, 32'd1);
        check("ignored_start not_queued", busy_late, 32'd0);

        // Reset in the middle of RUN discards the operation.
        start = 1'b1;
        a     = 16'h00FF;
        b     = 16'h0001;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("after_reset idle", done_cnt, 32'd0);

        t = '{16'h0002, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1};
        do_op(t, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
